// File: rtl/dino_game_pkg.sv
// Shared types and default constants for the dino game engine.
// DINO_SPEEDUP_EN (consumed by dino_game_engine) enables obstacle speed-up.
package dino_game_pkg;

  typedef logic [11:0]       coord_t;
  typedef logic signed [7:0] vel_t;
  typedef logic [3:0]        speed_t;
  typedef logic [1:0]        state_t;

  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_RUN       = 2'd1;
  localparam state_t ST_GAME_OVER = 2'd2;

  localparam coord_t     DINO_X_DEF           = 12'd100;
  localparam coord_t     GROUND_Y_DEF         = 12'd320;
  localparam coord_t     SPAWN_X_DEF          = 12'd680;
  localparam vel_t       JUMP_V_DEF           = 8'sd16;
  localparam vel_t       GRAVITY_DEF          = 8'sd1;
  localparam speed_t     OBST_SPEED_DEF       = 4'd4;
  localparam speed_t     MAX_SPEED_DEF        = 4'd12;
  localparam logic [7:0] SPEEDUP_INTERVAL_DEF = 8'd8;

  function automatic logic [31:0] zext_coord(input coord_t v);
    return {20'd0, v};
  endfunction

endpackage

// File: rtl/dino_jump_physics.sv
// Dino vertical motion: height, signed velocity and grounded flag, stepped once per frame tick.
module dino_jump_physics
  import dino_game_pkg::*;
#(
  parameter coord_t GROUND_Y = GROUND_Y_DEF,
  parameter vel_t   JUMP_V   = JUMP_V_DEF,
  parameter vel_t   GRAVITY  = GRAVITY_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   tick,
  input  logic   start,
  input  logic   hold,
  input  logic   init,
  output coord_t y,
  output logic   grounded
);

  coord_t             y_q, y_d;
  vel_t               v_q, v_d;
  logic               grounded_q, grounded_d;
  logic signed [12:0] y_next;
  logic signed [12:0] ground_s;

  always_comb begin
    // 13-bit signed so a tall jump clamps at the top instead of wrapping.
    y_next     = $signed({1'b0, y_q}) - $signed({{5{v_q[7]}}, v_q});
    ground_s   = $signed({1'b0, GROUND_Y});
    y_d        = y_q;
    v_d        = v_q;
    grounded_d = grounded_q;
    if (init) begin
      y_d        = GROUND_Y;
      v_d        = '0;
      grounded_d = 1'b1;
    end else if (tick && !hold) begin
      if (grounded_q) begin
        if (start) begin
          v_d        = JUMP_V;
          grounded_d = 1'b0;
        end
      end else if ((v_q <= 8'sd0) && (y_next >= ground_s)) begin
        y_d        = GROUND_Y;
        v_d        = '0;
        grounded_d = 1'b1;
      end else begin
        y_d = (y_next < 13'sd0) ? '0 : y_next[11:0];
        v_d = v_q - GRAVITY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q        <= GROUND_Y;
      v_q        <= '0;
      grounded_q <= 1'b1;
    end else begin
      y_q        <= y_d;
      v_q        <= v_d;
      grounded_q <= grounded_d;
    end
  end

  assign y        = y_q;
  assign grounded = grounded_q;

endmodule

// File: rtl/dino_game_engine.sv
// Frame-rate dino game logic: FSM, jump request, obstacle scroll/respawn, score and LFSR strobes.
// Define DINO_SPEEDUP_EN to raise obstacle speed every SPEEDUP_INTERVAL cleared obstacles.
module dino_game_engine
  import dino_game_pkg::*;
#(
  parameter coord_t DINO_X     = DINO_X_DEF,
  parameter coord_t GROUND_Y   = GROUND_Y_DEF,
  parameter vel_t   JUMP_V     = JUMP_V_DEF,
  parameter vel_t   GRAVITY    = GRAVITY_DEF,
  parameter coord_t SPAWN_X    = SPAWN_X_DEF,
  parameter speed_t OBST_SPEED = OBST_SPEED_DEF
`ifdef DINO_SPEEDUP_EN
  ,
  parameter speed_t     MAX_SPEED        = MAX_SPEED_DEF,
  parameter logic [7:0] SPEEDUP_INTERVAL = SPEEDUP_INTERVAL_DEF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screen_ready,
  input  logic        collision_detected,
  input  logic        jump_btn,
  output logic [31:0] x_coor,
  output logic [31:0] y_coor,
  output logic [31:0] x_coor_obstacle,
  output logic [31:0] y_coor_obstacle,
  output logic [1:0]  random_generator_clk,
  output logic [15:0] score,
  output logic        game_over,
  output state_t      dbg_state
);

  state_t      state_q, state_d;
  coord_t      x_obs_q, x_obs_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  strobe_q, strobe_d;
  logic        btn_s1_q, btn_s2_q, btn_s3_q;
  logic        jump_req_q, jump_req_d;
  logic        sr_s_q, sr_prev_q;
  logic        tick, btn_rise;
  logic        phys_start, phys_hold, phys_init, grounded;
  coord_t      dino_y;
  speed_t      speed_cur;
  coord_t      step;

`ifdef DINO_SPEEDUP_EN
  speed_t     speed_q, speed_d;
  logic [7:0] clr_cnt_q, clr_cnt_d;
  assign speed_cur = speed_q;
`else
  assign speed_cur = OBST_SPEED;
`endif

  // screen_ready is registered once before edge detection, so tick lands one cycle after the rise.
  assign tick     = sr_s_q & ~sr_prev_q;
  assign btn_rise = btn_s2_q & ~btn_s3_q;
  assign step     = {8'd0, speed_cur};

  always_comb begin
    state_d    = state_q;
    x_obs_d    = x_obs_q;
    score_d    = score_q;
    strobe_d   = strobe_q;
    phys_start = 1'b0;
    phys_hold  = 1'b1;
    phys_init  = 1'b0;
    // Every tick consumes or discards a pending request; a new edge in that cycle survives.
    jump_req_d = btn_rise | (jump_req_q & ~tick);
`ifdef DINO_SPEEDUP_EN
    speed_d    = speed_q;
    clr_cnt_d  = clr_cnt_q;
`endif
    if (tick) begin
      strobe_d = 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (jump_req_q) begin
            state_d     = ST_RUN;
            phys_start  = 1'b1;
            phys_hold   = 1'b0;
            strobe_d[1] = 1'b1;
          end
        end
        ST_RUN: begin
          if (collision_detected) begin
            state_d = ST_GAME_OVER;
          end else begin
            phys_hold   = 1'b0;
            phys_start  = jump_req_q;
            strobe_d[1] = jump_req_q & grounded;
            if (x_obs_q < step) begin
              x_obs_d     = SPAWN_X;
              score_d     = (score_q == 16'hFFFF) ? score_q : score_q + 16'd1;
              strobe_d[0] = 1'b1;
`ifdef DINO_SPEEDUP_EN
              if (clr_cnt_q == SPEEDUP_INTERVAL - 8'd1) begin
                clr_cnt_d = '0;
                if (speed_q < MAX_SPEED) speed_d = speed_q + 4'd1;
              end else begin
                clr_cnt_d = clr_cnt_q + 8'd1;
              end
`endif
            end else begin
              x_obs_d = x_obs_q - step;
            end
          end
        end
        ST_GAME_OVER: begin
          if (jump_req_q) begin
            state_d   = ST_IDLE;
            x_obs_d   = SPAWN_X;
            score_d   = '0;
            phys_init = 1'b1;
`ifdef DINO_SPEEDUP_EN
            speed_d   = OBST_SPEED;
            clr_cnt_d = '0;
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      x_obs_q    <= SPAWN_X;
      score_q    <= '0;
      strobe_q   <= '0;
      btn_s1_q   <= 1'b0;
      btn_s2_q   <= 1'b0;
      btn_s3_q   <= 1'b0;
      jump_req_q <= 1'b0;
      sr_s_q     <= 1'b0;
      sr_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_obs_q    <= x_obs_d;
      score_q    <= score_d;
      strobe_q   <= strobe_d;
      btn_s1_q   <= jump_btn;
      btn_s2_q   <= btn_s1_q;
      btn_s3_q   <= btn_s2_q;
      jump_req_q <= jump_req_d;
      sr_s_q     <= screen_ready;
      sr_prev_q  <= sr_s_q;
    end
  end

`ifdef DINO_SPEEDUP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      speed_q   <= OBST_SPEED;
      clr_cnt_q <= '0;
    end else begin
      speed_q   <= speed_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

  dino_jump_physics #(
    .GROUND_Y (GROUND_Y),
    .JUMP_V   (JUMP_V),
    .GRAVITY  (GRAVITY)
  ) u_physics (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (phys_start),
    .hold     (phys_hold),
    .init     (phys_init),
    .y        (dino_y),
    .grounded (grounded)
  );

  assign x_coor               = zext_coord(DINO_X);
  assign y_coor               = zext_coord(dino_y);
  assign x_coor_obstacle      = zext_coord(x_obs_q);
  assign y_coor_obstacle      = zext_coord(GROUND_Y);
  assign random_generator_clk = strobe_q;
  assign score                = score_q;
  assign game_over            = (state_q == ST_GAME_OVER);
  assign dbg_state            = state_q;

endmodule
